// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack data-memory
// handshake, a registered stall level for the execute stage, and a
// one-cycle-valid writeback bundle with fault reporting.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_flag,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_regwrite,
    output logic              wb_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // TIMEOUT tops out at 255, so TIMEOUT-1 always fits in 8 bits.
    localparam int          CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [REG_W-1:0]   lat_rd, lat_rd_nxt;
    logic               lat_regwrite, lat_regwrite_nxt;

    logic               mem_req_nxt, mem_we_nxt, stall_nxt;
    logic [DATA_W-1:0]  mem_addr_nxt, mem_wdata_nxt;
    logic               wb_valid_nxt, wb_regwrite_nxt, wb_err_nxt;
    logic [DATA_W-1:0]  wb_data_nxt;
    logic [REG_W-1:0]   wb_rd_nxt;

    // Next-state and next-output decode: accept a bundle in IDLE, wait for ack or timeout in ACCESS.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt        = state;
        cnt_nxt          = cnt;
        lat_rd_nxt       = lat_rd;
        lat_regwrite_nxt = lat_regwrite;
        mem_req_nxt      = mem_req;
        mem_we_nxt       = mem_we;
        mem_addr_nxt     = mem_addr;
        mem_wdata_nxt    = mem_wdata;
        stall_nxt        = stall_flag;
        wb_valid_nxt     = 1'b0;
        wb_data_nxt      = wb_data;
        wb_rd_nxt        = wb_rd;
        wb_regwrite_nxt  = wb_regwrite;
        wb_err_nxt       = wb_err;

        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_memread && !ex_memwrite) begin
                        // Plain ALU result: straight through in one cycle.
                        wb_valid_nxt    = 1'b1;
                        wb_data_nxt     = ex_result;
                        wb_rd_nxt       = ex_rd;
                        wb_regwrite_nxt = ex_regwrite;
                        wb_err_nxt      = 1'b0;
                    end else if ((ex_memread && ex_memwrite) || (ex_result[1:0] != 2'b00)) begin
                        // Illegal op or misaligned word: fault without touching memory.
                        wb_valid_nxt    = 1'b1;
                        wb_data_nxt     = ex_result;
                        wb_rd_nxt       = ex_rd;
                        wb_regwrite_nxt = 1'b0;
                        wb_err_nxt      = 1'b1;
                    end else begin
                        mem_req_nxt      = 1'b1;
                        mem_we_nxt       = ex_memwrite;
                        mem_addr_nxt     = ex_result;
                        mem_wdata_nxt    = ex_wdata;
                        lat_rd_nxt       = ex_rd;
                        lat_regwrite_nxt = ex_regwrite;
                        stall_nxt        = 1'b1;
                        cnt_nxt          = '0;
                        state_nxt        = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    // Ack beats a timeout landing in the same cycle.
                    mem_req_nxt     = 1'b0;
                    stall_nxt       = 1'b0;
                    wb_valid_nxt    = 1'b1;
                    wb_err_nxt      = 1'b0;
                    wb_rd_nxt       = lat_rd;
                    wb_data_nxt     = mem_we ? mem_wdata : mem_rdata;
                    wb_regwrite_nxt = mem_we ? 1'b0 : lat_regwrite;
                    state_nxt       = IDLE;
                end else if (cnt == CNT_LAST) begin
                    mem_req_nxt     = 1'b0;
                    stall_nxt       = 1'b0;
                    wb_valid_nxt    = 1'b1;
                    wb_err_nxt      = 1'b1;
                    wb_regwrite_nxt = 1'b0;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            stall_flag   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wb_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            lat_rd       <= lat_rd_nxt;
            lat_regwrite <= lat_regwrite_nxt;
            mem_req      <= mem_req_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            stall_flag   <= stall_nxt;
            wb_valid     <= wb_valid_nxt;
            wb_data      <= wb_data_nxt;
            wb_rd        <= wb_rd_nxt;
            wb_regwrite  <= wb_regwrite_nxt;
            wb_err       <= wb_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions, with
// expected writeback bundles derived per transaction from the stage's rules.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid, ex_memread, ex_memwrite, ex_regwrite;
    logic [DW-1:0] ex_result, ex_wdata;
    logic [RW-1:0] ex_rd;
    logic          mem_req, mem_we, mem_ack;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          stall_flag, wb_valid, wb_regwrite, wb_err;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;

    int total = 0;
    int bad   = 0;

    mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_result   (ex_result),
        .ex_wdata    (ex_wdata),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_regwrite (ex_regwrite),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_flag  (stall_flag),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One idle cycle (optionally with a stray ack); nothing may come out.
    task automatic idle_cycle(input logic stray_ack);
        ex_valid  = 1'b0;
        mem_ack   = stray_ack;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_wb_valid", 32'(wb_valid), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
        check("idle_stall", 32'(stall_flag), 32'd0);
    endtask

    // One transaction, entered and left at a negedge. ack_delay = index of
    // the ACCESS cycle carrying mem_ack (1 = first); outside 1..TO = no ack.
    task automatic run_op(input logic rd_op, input logic wr_op,
                          input logic [31:0] result, input logic [31:0] wdata,
                          input logic [RW-1:0] rd, input logic regw,
                          input int ack_delay, input logic [31:0] rdata,
                          input logic noise);
        logic is_mem, fault, acked;
        is_mem = rd_op | wr_op;
        fault  = is_mem && ((rd_op && wr_op) || (result[1:0] != 2'b00));
        acked  = (ack_delay >= 1) && (ack_delay <= TO);

        ex_valid    = 1'b1;
        ex_memread  = rd_op;
        ex_memwrite = wr_op;
        ex_result   = result;
        ex_wdata    = wdata;
        ex_rd       = rd;
        ex_regwrite = regw;
        @(negedge clk);

        if (!is_mem || fault) begin
            check("direct_wb_valid", 32'(wb_valid), 32'd1);
            check("direct_wb_data", wb_data, result);
            check("direct_wb_rd", 32'(wb_rd), 32'(rd));
            check("direct_wb_regwrite", 32'(wb_regwrite), fault ? 32'd0 : 32'(regw));
            check("direct_wb_err", 32'(wb_err), 32'(fault));
            check("direct_mem_req", 32'(mem_req), 32'd0);
            check("direct_stall", 32'(stall_flag), 32'd0);
            ex_valid = 1'b0;
        end else begin
            check("issue_mem_we", 32'(mem_we), 32'(wr_op));
            if (wr_op) check("issue_mem_wdata", mem_wdata, wdata);
            for (int i = 1; i <= TO; i++) begin
                check("access_mem_req", 32'(mem_req), 32'd1);
                check("access_stall", 32'(stall_flag), 32'd1);
                check("access_mem_addr", mem_addr, result);
                check("access_wb_valid", 32'(wb_valid), 32'd0);
                ex_valid = noise;
                if (noise) begin
                    ex_result   = $urandom;
                    ex_wdata    = $urandom;
                    ex_rd       = RW'($urandom);
                    ex_memread  = 1'($urandom);
                    ex_memwrite = 1'($urandom);
                    ex_regwrite = 1'b1;
                end
                mem_ack   = (i == ack_delay);
                mem_rdata = (i == ack_delay) ? rdata : $urandom;
                @(negedge clk);
                mem_ack = 1'b0;
                if (i == ack_delay) break;
            end
            ex_valid = 1'b0;
            check("done_wb_valid", 32'(wb_valid), 32'd1);
            check("done_mem_req", 32'(mem_req), 32'd0);
            check("done_stall", 32'(stall_flag), 32'd0);
            check("done_wb_err", 32'(wb_err), acked ? 32'd0 : 32'd1);
            if (acked) begin
                check("done_wb_rd", 32'(wb_rd), 32'(rd));
                check("done_wb_data", wb_data, wr_op ? wdata : rdata);
                check("done_wb_regwrite", 32'(wb_regwrite), wr_op ? 32'd0 : 32'(regw));
            end else begin
                check("timeout_wb_regwrite", 32'(wb_regwrite), 32'd0);
            end
        end
        idle_cycle(1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        ex_valid    = 1'b0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_regwrite = 1'b0;
        ex_result   = '0;
        ex_wdata    = '0;
        ex_rd       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(negedge clk);

        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall", 32'(stall_flag), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Pass-through, load with 3-cycle ack, store with noisy ex inputs.
        run_op(1'b0, 1'b0, 32'h0000002A, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 32'h00000010, 32'h0, 5'd8, 1'b1, 3, 32'hDEADBEEF, 1'b0);
        run_op(1'b0, 1'b1, 32'h00000020, 32'h12345678, 5'd3, 1'b1, 1, 32'h0, 1'b1);

        // Faults: misaligned load, illegal read+write.
        run_op(1'b1, 1'b0, 32'h00000013, 32'h0, 5'd9, 1'b1, 1, 32'h0, 1'b0);
        run_op(1'b1, 1'b1, 32'h00000020, 32'h0, 5'd10, 1'b1, 1, 32'h0, 1'b0);

        // Timeout with no ack, then ack landing in the last allowed cycle.
        run_op(1'b1, 1'b0, 32'h00000040, 32'h0, 5'd11, 1'b1, 0, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 32'h00000044, 32'h0, 5'd12, 1'b1, TO, 32'hCAFEF00D, 1'b0);

        // Ack while idle is ignored.
        idle_cycle(1'b1);

        // Reset in the middle of an access.
        ex_valid    = 1'b1;
        ex_memread  = 1'b1;
        ex_memwrite = 1'b0;
        ex_result   = 32'h00000080;
        ex_rd       = 5'd7;
        ex_regwrite = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall_flag), 32'd0);
        check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_stall", 32'(stall_flag), 32'd0);

        // Randomized mix of operations.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 4);
            addr = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: run_op(1'b0, 1'b0, $urandom, $urandom, RW'($urandom), 1'($urandom), 0, 32'h0, 1'b0);
                1: run_op(1'b1, 1'b0, addr, $urandom, RW'($urandom), 1'($urandom),
                          $urandom_range(1, TO + 2), $urandom, 1'($urandom));
                2: run_op(1'b0, 1'b1, addr, $urandom, RW'($urandom), 1'($urandom),
                          $urandom_range(1, TO + 2), $urandom, 1'($urandom));
                3: run_op(1'b1, 1'b0, addr | 32'($urandom_range(1, 3)), $urandom, RW'($urandom), 1'b1,
                          1, 32'h0, 1'b0);
                default: run_op(1'b1, 1'b1, addr, $urandom, RW'($urandom), 1'b1, 1, 32'h0, 1'b0);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
